shi_alarm: RTL

Hours stage of the DE2-115 digital clock, directly downstream of the minutes counter. Advances a 0–23 hour count on the minutes stage's end-of-hour carry and supports manual hour adjustment from a key. Holds the alarm-hour register. Compares the full time against the alarm setting and drives a timed, pulsed buzzer until it times out or is cancelled.

---
 rtl/shi_alarm_if.sv | 29 ++
 rtl/shi_alarm.sv | 127 ++++++++++++
 2 files changed

// File: rtl/shi_alarm_if.sv
// Hours-stage signal bundle: time/alarm inputs from upstream stages, hour/alarm outputs.
// Pure wiring; no latency of its own.
// No backpressure: every signal is a level or a single-cycle strobe.
interface shi_alarm_if;
  logic       sec_tick;
  logic       cin;
  logic [7:0] secin;
  logic [7:0] minin;
  logic [7:0] alarm_min;
  logic       am;
  logic       naozhong;
  logic       stop_n;
  logic [7:0] qout;
  logic [7:0] nout;
  logic       ringing;
  logic       buzz;

  // Upstream / stimulus side
  modport master (
    output sec_tick, cin, secin, minin, alarm_min, am, naozhong, stop_n,
    input  qout, nout, ringing, buzz
  );

  // Hours stage side
  modport slave (
    input  sec_tick, cin, secin, minin, alarm_min, am, naozhong, stop_n,
    output qout, nout, ringing, buzz
  );
endinterface

// File: rtl/shi_alarm.sv
// Hours counter (0-23) with key adjust, alarm-hour register and timed pulsed buzzer.
// Latency: carry -> qout 1 cycle; key -> qout/nout/ring-exit 3 cycles; match -> ringing 1 cycle.
// No backpressure: strobes are consumed in the cycle they arrive.
module shi_alarm #(
  parameter int RING_SECS = 30,
  parameter int BEEP_DIV  = 12_500_000
) (
  input logic      clk,
  input logic      reset,
  shi_alarm_if.slave bus
);

  localparam int             BW        = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
  localparam logic [BW-1:0]  BEEP_LAST = BW'(BEEP_DIV - 1);
  localparam logic [7:0]     RING_LAST = 8'(RING_SECS - 1);

  typedef enum logic {IDLE, RING} state_t;

  // [0] first sync stage, [1] second sync stage, [2] previous value of [1]
  logic [2:0]    am_sync_q,   am_sync_d;
  logic [2:0]    stop_sync_q, stop_sync_d;
  logic [7:0]    qout_q,      qout_d;
  logic [7:0]    nout_q,      nout_d;
  logic          match_d_q,   match_d_d;
  state_t        state_q,     state_d;
  logic [7:0]    ring_cnt_q,  ring_cnt_d;
  logic [BW-1:0] beep_cnt_q,  beep_cnt_d;
  logic          beep_ph_q,   beep_ph_d;
  logic          ringing_q,   ringing_d;
  logic          buzz_q,      buzz_d;

  logic am_fall, stop_fall, carry, match;

  function automatic logic [7:0] hr_inc(input logic [7:0] h);
    return (h == 8'd23) ? 8'd0 : h + 8'd1;
  endfunction

  assign am_fall   = !am_sync_q[1]   && am_sync_q[2];
  assign stop_fall = !stop_sync_q[1] && stop_sync_q[2];
  assign carry     = bus.sec_tick && bus.cin;
  assign match     = (qout_q == nout_q) && (bus.minin == bus.alarm_min) &&
                     (bus.secin == 8'd0) && !bus.naozhong;

  // Next-state logic for counters, synchronizers and the alarm FSM
  always_comb begin
    am_sync_d   = {am_sync_q[1:0], bus.am};
    stop_sync_d = {stop_sync_q[1:0], bus.stop_n};
    match_d_d   = match;

    // Carry and key in the same cycle collapse into one increment
    qout_d = qout_q;
    if (carry || (am_fall && !bus.naozhong)) qout_d = hr_inc(qout_q);

    nout_d = nout_q;
    if (am_fall && bus.naozhong) nout_d = hr_inc(nout_q);

    // Beep divider free-runs; it is re-phased on RING entry below
    if (beep_cnt_q == BEEP_LAST) begin
      beep_cnt_d = '0;
      beep_ph_d  = !beep_ph_q;
    end else begin
      beep_cnt_d = beep_cnt_q + 1'b1;
      beep_ph_d  = beep_ph_q;
    end

    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    case (state_q)
      IDLE: begin
        // Only the rising edge of match arms; a held match cannot retrigger
        if (match && !match_d_q) begin
          state_d    = RING;
          ring_cnt_d = 8'd0;
          beep_cnt_d = '0;
          beep_ph_d  = 1'b1;
        end
      end
      RING: begin
        if (stop_fall || bus.naozhong ||
            (bus.sec_tick && ring_cnt_q == RING_LAST)) begin
          state_d = IDLE;
        end else if (bus.sec_tick) begin
          ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    ringing_d = (state_d == RING);
    buzz_d    = (state_d == RING) && beep_ph_d;
  end

  // State register; key synchronizers preset idle so reset release is edge-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      am_sync_q   <= 3'b111;
      stop_sync_q <= 3'b111;
      qout_q      <= 8'd0;
      nout_q      <= 8'd0;
      match_d_q   <= 1'b0;
      state_q     <= IDLE;
      ring_cnt_q  <= 8'd0;
      beep_cnt_q  <= '0;
      beep_ph_q   <= 1'b1;
      ringing_q   <= 1'b0;
      buzz_q      <= 1'b0;
    end else begin
      am_sync_q   <= am_sync_d;
      stop_sync_q <= stop_sync_d;
      qout_q      <= qout_d;
      nout_q      <= nout_d;
      match_d_q   <= match_d_d;
      state_q     <= state_d;
      ring_cnt_q  <= ring_cnt_d;
      beep_cnt_q  <= beep_cnt_d;
      beep_ph_q   <= beep_ph_d;
      ringing_q   <= ringing_d;
      buzz_q      <= buzz_d;
    end
  end

  assign bus.qout    = qout_q;
  assign bus.nout    = nout_q;
  assign bus.ringing = ringing_q;
  assign bus.buzz    = buzz_q;

endmodule
